// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared op and sequencer-state encodings for the multi-cycle
//                MULT/MULTU/DIV/DIVU engine.
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_pkg;

  // Operation select as issued by the EX stage.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer_if
//  Description : Issue/result bundle between the EX stage (master) and the
//                multiply/divide engine (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface muldiv_sequencer_if #(
  parameter int N = 32
);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] rs_val;
  logic [N-1:0] rt_val;
  logic         hi_we;
  logic         lo_we;
  logic [N-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_datapath
//  Description : Shared N-bit add/sub unit plus the {acc, work} shift pair.
//                Multiply: shift-add, {C, acc, work} >> 1 each step.
//                Divide  : restoring, {acc, work} << 1 then trial subtract.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_datapath #(
  parameter int N = 32
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         i_load,    // load operands, clear accumulator
  input  wire logic         i_step,    // perform one iteration
  input  wire logic         i_add_n,   // 1: subtract (divide), 0: add (multiply)
  input  wire logic [N-1:0] i_init_m,  // |rs| for multiply, |divisor| for divide
  input  wire logic [N-1:0] i_init_w,  // |rt| for multiply, |dividend| for divide
  output logic      [N-1:0] o_acc,     // product high / remainder
  output logic      [N-1:0] o_work     // product low / quotient
);

  logic [N-1:0] r_acc;
  logic [N-1:0] r_work;
  logic [N-1:0] r_m;

  logic [N-1:0] w_rsh;
  logic [N-1:0] w_a;
  logic [N-1:0] w_b;
  logic [N-1:0] w_sum;
  logic         w_cout;
  logic         w_div_ok;

  // Operand steering into the single adder and trial-subtract outcome.
  always_comb begin
    w_rsh = {r_acc[N-2:0], r_work[N-1]};
    if (i_add_n) begin
      w_a = w_rsh;
      w_b = ~r_m;
    end else begin
      w_a = r_acc;
      w_b = r_work[0] ? r_m : '0;
    end
    {w_cout, w_sum} = {1'b0, w_a} + {1'b0, w_b} + {{N{1'b0}}, i_add_n};
    // A bit shifted out of the remainder means it already exceeds any
    // N-bit divisor, so the subtract succeeds regardless of the carry.
    w_div_ok = w_cout | r_acc[N-1];
  end

  // Working registers: load in PREP, one shift/add(sub) per ITER cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_work <= '0;
      r_m    <= '0;
    end else if (i_load) begin
      r_acc  <= '0;
      r_work <= i_init_w;
      r_m    <= i_init_m;
    end else if (i_step) begin
      if (i_add_n) begin
        r_acc  <= w_div_ok ? w_sum : w_rsh;
        r_work <= {r_work[N-2:0], w_div_ok};
      end else begin
        r_acc  <= {w_cout, w_sum[N-1:1]};
        r_work <= {w_sum[0], r_work[N-1:1]};
      end
    end
  end

  assign o_acc  = r_acc;
  assign o_work = r_work;

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU engine with architectural
//                HI/LO and MTHI/MTLO writes. Fixed N+3 edge latency.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int N     = 32,
  parameter int CNT_W = 6
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  muldiv_sequencer_if.slave bus
);
  import muldiv_pkg::*;

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(N - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [N-1:0]     r_rs;
  logic [N-1:0]     r_rt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [N-1:0]     r_hi;
  logic [N-1:0]     r_lo;
  logic             r_dbz;

  logic             w_busy;
  logic             w_done;
  logic             w_accept;
  logic             w_signed;
  logic             w_is_div;
  logic             w_dbz;
  logic             w_load;
  logic             w_step;
  logic [N-1:0]     w_abs_rs;
  logic [N-1:0]     w_abs_rt;
  logic [N-1:0]     w_init_m;
  logic [N-1:0]     w_init_w;
  logic [N-1:0]     w_acc;
  logic [N-1:0]     w_work;
  logic [N-1:0]     w_quo;
  logic [N-1:0]     w_rem;
  logic [2*N-1:0]   w_prod;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_PREP;
      S_PREP: begin
        w_busy      = 1'b1;
        w_state_nxt = S_ITER;
      end
      S_ITER: begin
        w_busy = 1'b1;
        if (r_cnt == c_last_iter) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_busy      = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = bus.start ? S_PREP : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_signed = (r_op == OP_MULT) || (r_op == OP_DIV);
  assign w_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);
  assign w_dbz    = w_is_div && (r_rt == '0);
  assign w_load   = (r_state == S_PREP);
  assign w_step   = (r_state == S_ITER);

  // Operands are captured once on acceptance and held for the whole op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= OP_MULT;
      r_rs <= '0;
      r_rt <= '0;
    end else if (w_accept) begin
      r_op <= bus.op;
      r_rs <= bus.rs_val;
      r_rt <= bus.rt_val;
    end
  end

  // Result signs recorded in PREP; iteration counter runs through ITER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == S_PREP) begin
      r_sign_q <= w_signed & (r_rs[N-1] ^ r_rt[N-1]);
      r_sign_r <= w_signed & r_rs[N-1];
      r_cnt    <= '0;
    end else if (r_state == S_ITER) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Magnitudes for signed ops and operand routing into the datapath.
  always_comb begin
    w_abs_rs = (w_signed && r_rs[N-1]) ? -r_rs : r_rs;
    w_abs_rt = (w_signed && r_rt[N-1]) ? -r_rt : r_rt;
    if (w_is_div) begin
      w_init_m = w_abs_rt;
      w_init_w = w_abs_rs;
    end else begin
      w_init_m = w_abs_rs;
      w_init_w = w_abs_rt;
    end
  end

  muldiv_datapath #(
    .N (N)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_add_n  (w_is_div),
    .i_init_m (w_init_m),
    .i_init_w (w_init_w),
    .o_acc    (w_acc),
    .o_work   (w_work)
  );

  // Sign fix-up of the unsigned magnitude results.
  always_comb begin
    w_prod = {w_acc, w_work};
    if (w_signed && r_sign_q) w_prod = -w_prod;
    w_quo = (w_signed && r_sign_q) ? -w_work : w_work;
    w_rem = (w_signed && r_sign_r) ? -w_acc : w_acc;
  end

  // HI/LO: results land in FIX; MTHI/MTLO only while not busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_dbz <= 1'b0;
    end else if (r_state == S_FIX) begin
      r_dbz <= w_dbz;
      if (w_dbz) begin
        r_hi <= r_rs;
        r_lo <= '1;
      end else if (w_is_div) begin
        r_hi <= w_rem;
        r_lo <= w_quo;
      end else begin
        r_hi <= w_prod[2*N-1:N];
        r_lo <= w_prod[N-1:0];
      end
    end else if (!w_busy) begin
      if (bus.hi_we) r_hi <= bus.wdata;
      if (bus.lo_we) r_lo <= bus.wdata;
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.div_by_zero = w_done & r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_sequencer
//  Description : Self-checking bench for muldiv_sequencer against an
//                arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_sequencer;

  localparam int N = 32;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  muldiv_sequencer_if #(.N(N)) bus ();

  muldiv_sequencer #(
    .N     (N),
    .CNT_W (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, C-style truncating division.
  function automatic void model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint          sa = longint'($signed(rs));
    longint          sb = longint'($signed(rt));
    longint unsigned ua = {32'd0, rs};
    longint unsigned ub = {32'd0, rt};
    logic [63:0]     p;
    logic [63:0]     q;
    logic [63:0]     r;
    z = 1'b0;
    h = '0;
    l = '0;
    if (op[1] && rt == 32'd0) begin
      h = rs;
      l = 32'hFFFF_FFFF;
      z = 1'b1;
    end else begin
      case (op)
        2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
        2'b01: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
        2'b10: begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
        default: begin q = ua / ub; r = ua % ub; h = r[31:0]; l = q[31:0]; end
      endcase
    end
  endfunction

  // Issue one op (engine must be in IDLE or DONE), wait for done and check
  // latency, per-edge status and results. Returns with done visible.
  // inj: edge at which a stray start + MTHI is pulsed (0 = none).
  // mt_start: perform MTHI in the same cycle as the accepted start.
  task automatic do_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input int inj, input bit mt_start);
    logic [31:0] ehi, elo, hi_before;
    logic        ez;
    int          e;
    model(op, rs, rt, ehi, elo, ez);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
    if (mt_start) begin
      bus.hi_we = 1'b1;
      bus.wdata = 32'h5A5A_0001;
    end
    tick();
    e = 1;
    bus.start  = 1'b0;
    bus.hi_we  = 1'b0;
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
    bus.op     = 2'($urandom_range(0, 3));
    if (mt_start) check("mthi_with_start", bus.hi, 32'h5A5A_0001);
    hi_before = bus.hi;
    while (e < 40) begin
      if (bus.done) break;
      check("status_busy", {bus.busy, bus.done, bus.div_by_zero}, 3'b100);
      if (e == inj - 1) begin
        bus.start  = 1'b1;
        bus.hi_we  = 1'b1;
        bus.wdata  = 32'h0000_1234;
        bus.op     = 2'b00;
        bus.rs_val = 32'd3;
        bus.rt_val = 32'd3;
      end
      tick();
      e++;
      if (e == inj) begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        check("mthi_dropped_busy", bus.hi, hi_before);
      end
    end
    check("latency_edges", e, 35);
    check("done_busy", {bus.busy, bus.done}, 2'b01);
    check("result_hi", bus.hi, ehi);
    check("result_lo", bus.lo, elo);
    check("div_by_zero", bus.div_by_zero, ez);
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0: v = $urandom_range(0, 20);
      1: v = -$urandom_range(1, 20);
      2: v = 32'h8000_0000;
      3: v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int          done_seen;
    logic [1:0]  rop;
    logic [31:0] rrs, rrt;
    n_tests      = 0;
    n_fail       = 0;
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.rs_val   = '0;
    bus.rt_val   = '0;
    bus.hi_we    = 1'b0;
    bus.lo_we    = 1'b0;
    bus.wdata    = '0;
    rst_n        = 1'b1;
    #1 rst_n     = 1'b0;
    #1;

    // Reset state.
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_status", {bus.busy, bus.done, bus.div_by_zero}, 3'b000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed ops.
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    check("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_max_lo", bus.lo, 32'h0000_0001);
    tick();
    check("done_one_cycle", {bus.busy, bus.done}, 2'b00);
    do_op(2'b00, -32'd3, 32'd5, 0, 1'b0);
    tick();
    do_op(2'b10, -32'd7, 32'd2, 0, 1'b0);
    tick();
    do_op(2'b11, 32'd7, 32'd0, 0, 1'b1);
    tick();
    check("dbz_one_cycle", {bus.done, bus.div_by_zero}, 2'b00);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    tick();
    do_op(2'b10, 32'd9, 32'd0, 0, 1'b0);
    tick();

    // Stray start + MTHI while busy, then back-to-back issue from DONE.
    do_op(2'b11, 32'd100, 32'd7, 10, 1'b0);
    check("divu_100_7_hi", bus.hi, 32'd2);
    check("divu_100_7_lo", bus.lo, 32'd14);
    do_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1'b0);
    tick();

    // Randomized ops, some back-to-back.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      rrs = rnd_val();
      rrt = ($urandom_range(0, 7) == 0) ? 32'd0 : rnd_val();
      do_op(rop, rrs, rrt, 0, 1'b0);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();

    // MTHI/MTLO in IDLE.
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    tick();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("mthi_idle", bus.hi, 32'hDEAD_BEEF);
    check("mtlo_idle", bus.lo, 32'hDEAD_BEEF);

    // Asynchronous reset in the middle of ITER.
    bus.start  = 1'b1;
    bus.op     = 2'b11;
    bus.rs_val = 32'd1000;
    bus.rt_val = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (15) tick();
    check("pre_reset_busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_hi", bus.hi, 32'd0);
    check("async_rst_lo", bus.lo, 32'd0);
    check("async_rst_status", {bus.busy, bus.done}, 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done || bus.busy) done_seen++;
    end
    check("no_done_after_reset", done_seen, 0);

    // MTLO after reset.
    bus.lo_we = 1'b1;
    bus.wdata = 32'hA5A5_A5A5;
    tick();
    bus.lo_we = 1'b0;
    check("mtlo_after_reset", bus.lo, 32'hA5A5_A5A5);
    check("hi_after_reset", bus.hi, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
